// File: rtl/lane_run_detector_pkg.sv
// Shared types and width helpers for the lane run detector (package lane_pkg).
package lane_pkg;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

  localparam int unsigned IMG_W_DFLT = 32'd640;
  localparam int unsigned IMG_H_DFLT = 32'd480;
  localparam int unsigned ROW_W_DFLT = idx_w(IMG_H_DFLT);
  localparam int unsigned X_W_DFLT   = idx_w(IMG_W_DFLT);
  localparam int unsigned WID_W_DFLT = $clog2(IMG_W_DFLT + 32'd1);

  // Run record for the default 640x480 geometry; the top derives its own for other sizes.
  typedef struct packed {
    logic [ROW_W_DFLT-1:0] row;
    logic [X_W_DFLT-1:0]   x;
    logic [WID_W_DFLT-1:0] width;
  } lane_run_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_e;

endpackage

// File: rtl/lane_run_detector_if.sv
// Pixel input and run-record output bundle of the lane run detector.
interface lane_run_detector_if #(
  parameter int unsigned ROW_W = 9,
  parameter int unsigned X_W   = 10,
  parameter int unsigned WID_W = 10
);
  logic             pix_valid;
  logic             pix_bit;
  logic             out_valid;
  logic             out_ready;
  logic [ROW_W-1:0] out_row;
  logic [X_W-1:0]   out_x;
  logic [WID_W-1:0] out_width;

  modport master (
    output pix_valid, pix_bit, out_ready,
    input  out_valid, out_row, out_x, out_width
  );

  modport slave (
    input  pix_valid, pix_bit, out_ready,
    output out_valid, out_row, out_x, out_width
  );
endinterface

// File: rtl/lane_run_detector_fifo.sv
// First-word-fall-through record queue; head entry is visible whenever not empty.
module lane_run_fifo
  import lane_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = lane_run_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);
  localparam int unsigned AW = idx_w(DEPTH);

  T           mem_q [DEPTH];
  logic [AW:0] wr_q;
  logic [AW:0] rd_q;
  logic        do_push_s;
  logic        do_pop_s;

  // Full-with-pop frees the head slot on the same edge, so the push is allowed.
  always_comb begin
    do_pop_s  = pop_i & ~empty_o;
    do_push_s = push_i & (~full_o | do_pop_s);
  end

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign data_o  = mem_q[rd_q[AW-1:0]];

  // Storage and pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push_s) begin
        mem_q[wr_q[AW-1:0]] <= data_i;
        wr_q                <= wr_q + (AW+1)'(1);
      end
      if (do_pop_s) begin
        rd_q <= rd_q + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/lane_run_detector.sv
// Finds horizontal runs in the lane-mask stream and queues width-qualified {row, x, width} records.
// Optional LANE_RUN_DROP_CNT_EN adds a saturating counter of records lost to a full queue.
module lane_run_detector
  import lane_pkg::*;
#(
  parameter int unsigned IMG_W      = 640,
  parameter int unsigned IMG_H      = 480,
  parameter int unsigned MIN_W      = 3,
  parameter int unsigned MAX_W      = 40,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  lane_run_detector_if.slave  bus,
  output logic                frame_end
`ifdef LANE_RUN_DROP_CNT_EN
  ,
  output logic [15:0]         drop_cnt
`endif
);
  localparam int unsigned RB = idx_w(IMG_H);
  localparam int unsigned XB = idx_w(IMG_W);
  localparam int unsigned WB = $clog2(IMG_W + 32'd1);

  typedef struct packed {
    logic [RB-1:0] row;
    logic [XB-1:0] x;
    logic [WB-1:0] width;
  } rec_t;

  logic [XB-1:0] col_q, col_d;
  logic [RB-1:0] row_q, row_d;
  run_state_e    state_q, state_d;
  logic [XB-1:0] xs_q, xs_d;
  logic [WB-1:0] len_q, len_d;
  logic          frame_end_q, frame_end_d;

  logic          last_col_s, last_row_s;
  logic          term_s, qual_s, push_ok_s;
  logic [XB-1:0] term_x_s;
  logic [WB-1:0] term_len_s;
  logic          fifo_full_s, fifo_empty_s;
  rec_t          rec_s, head_s;

  assign last_col_s = (col_q == XB'(IMG_W - 32'd1));
  assign last_row_s = (row_q == RB'(IMG_H - 32'd1));

  // Raster position; frame_end is set by the edge that samples the last pixel of the frame.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    frame_end_d = 1'b0;
    if (bus.pix_valid) begin
      if (last_col_s) begin
        col_d       = '0;
        row_d       = last_row_s ? '0 : row_q + RB'(1);
        frame_end_d = last_row_s;
      end else begin
        col_d = col_q + XB'(1);
      end
    end else begin
      frame_end_d = 1'b0;
    end
  end

  // Run tracker: the last column of a row always closes the run, including that pixel if set.
  always_comb begin
    state_d    = state_q;
    xs_d       = xs_q;
    len_d      = len_q;
    term_s     = 1'b0;
    term_x_s   = xs_q;
    term_len_s = len_q;
    if (bus.pix_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.pix_bit) begin
            if (last_col_s) begin
              term_s     = 1'b1;
              term_x_s   = col_q;
              term_len_s = WB'(1);
            end else begin
              state_d = ST_RUN;
              xs_d    = col_q;
              len_d   = WB'(1);
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (bus.pix_bit && !last_col_s) begin
            len_d = len_q + WB'(1);
          end else begin
            term_s     = 1'b1;
            term_len_s = bus.pix_bit ? (len_q + WB'(1)) : len_q;
            state_d    = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Width filter and queue admission.
  always_comb begin
    qual_s       = term_s && (term_len_s >= WB'(MIN_W)) && (term_len_s <= WB'(MAX_W));
    push_ok_s    = ~fifo_full_s | (bus.out_ready & ~fifo_empty_s);
    rec_s.row    = row_q;
    rec_s.x      = term_x_s;
    rec_s.width  = term_len_s;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      state_q     <= ST_IDLE;
      xs_q        <= '0;
      len_q       <= '0;
      frame_end_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      state_q     <= state_d;
      xs_q        <= xs_d;
      len_q       <= len_d;
      frame_end_q <= frame_end_d;
    end
  end

  lane_run_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (rec_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (qual_s & push_ok_s),
    .data_i  (rec_s),
    .pop_i   (bus.out_ready),
    .data_o  (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign bus.out_valid = ~fifo_empty_s;
  assign bus.out_row   = head_s.row;
  assign bus.out_x     = head_s.x;
  assign bus.out_width = head_s.width;
  assign frame_end     = frame_end_q;

`ifdef LANE_RUN_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  // Saturating count of qualifying runs that found no room in the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= 16'd0;
    end else if (qual_s && !push_ok_s && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_lane_run_detector.sv
// Directed bench for lane_run_detector on a 16x4 image, MIN_W=2, MAX_W=6, depth 4.
module tb_lane_run_detector;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic frame_end;
`ifdef LANE_RUN_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;

  typedef struct packed {
    logic [1:0] r;
    logic [3:0] x;
    logic [4:0] w;
  } exp_rec_t;

  exp_rec_t rec_q[$];

  always #5 clk = ~clk;

  lane_run_detector_if #(.ROW_W(2), .X_W(4), .WID_W(5)) bus ();

  lane_run_detector #(
    .IMG_W      (16),
    .IMG_H      (4),
    .MIN_W      (2),
    .MAX_W      (6),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .frame_end (frame_end)
`ifdef LANE_RUN_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  // Collect every record the consumer accepts, and count frame_end pulses.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
      rec_q.push_back({bus.out_row, bus.out_x, bus.out_width});
    if (frame_end === 1'b1)
      fe_cnt <= fe_cnt + 1;
  end

  task automatic step(input logic v, input logic b);
    @(posedge clk);
    #1;
    bus.pix_valid = v;
    bus.pix_bit   = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic drive_row(input logic [15:0] bits);
    for (int c = 0; c < 16; c++) step(1'b1, bits[15-c]);
  endtask

  task automatic test_reset();
    bus.pix_valid = 1'b0;
    bus.pix_bit   = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", bus.out_valid); end
    checks++;
    if ({bus.out_row, bus.out_x, bus.out_width} !== 11'd0) begin
      errors++; $display("FAIL reset_fields: got %h, required 0", {bus.out_row, bus.out_x, bus.out_width});
    end
    checks++;
    if (frame_end !== 1'b0) begin errors++; $display("FAIL reset_frame_end: got %b, required 0", frame_end); end
`ifdef LANE_RUN_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d, required 0", drop_cnt); end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_single_run();
    logic [15:0] bits;
    bits = 16'b0001111000000000;
    bus.out_ready = 1'b1;
    rec_q.delete();
    for (int c = 0; c < 16; c++) begin
      step(1'b1, bits[15-c]);
      @(negedge clk);
      if (c == 7) begin
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_early: out_valid got %b, required 0", bus.out_valid); end
      end
      if (c == 8) begin
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_latency: out_valid got %b, required 1", bus.out_valid); end
        checks++;
        if ({bus.out_row, bus.out_x, bus.out_width} !== {2'd0, 4'd3, 5'd4}) begin
          errors++; $display("FAIL single_head: got r%0d x%0d w%0d, required r0 x3 w4", bus.out_row, bus.out_x, bus.out_width);
        end
      end
    end
    idle(2);
    checks++;
    if (rec_q.size() != 1) begin errors++; $display("FAIL single_count: got %0d, required 1", rec_q.size()); end
    else begin
      checks++;
      if (rec_q[0] !== {2'd0, 4'd3, 5'd4}) begin errors++; $display("FAIL single_rec: got %h, required %h", rec_q[0], {2'd0, 4'd3, 5'd4}); end
    end
  endtask

  task automatic test_width_filter();
    rec_q.delete();
    drive_row(16'b0010011111110000);
    idle(3);
    checks++;
    if (rec_q.size() != 0) begin errors++; $display("FAIL filter_count: got %0d, required 0", rec_q.size()); end
  endtask

  task automatic test_end_of_line();
    exp_rec_t e [2];
    e[0] = {2'd2, 4'd13, 5'd3};
    e[1] = {2'd3, 4'd0, 5'd2};
    rec_q.delete();
    drive_row(16'b0000000000000111);
    drive_row(16'b1100000000000000);
    idle(3);
    checks++;
    if (rec_q.size() != 2) begin errors++; $display("FAIL eol_count: got %0d, required 2", rec_q.size()); end
    for (int i = 0; i < 2 && i < rec_q.size(); i++) begin
      checks++;
      if (rec_q[i] !== e[i]) begin errors++; $display("FAIL eol_rec%0d: got %h, required %h", i, rec_q[i], e[i]); end
    end
    checks++;
    if (fe_cnt != 1) begin errors++; $display("FAIL first_frame_end: got %0d pulses, required 1", fe_cnt); end
  endtask

  task automatic test_overflow();
    bus.out_ready = 1'b0;
    rec_q.delete();
    drive_row(16'b1101101101101100);
    idle(4);
    checks++;
    if (bus.out_valid !== 1'b1 || {bus.out_row, bus.out_x, bus.out_width} !== {2'd0, 4'd0, 5'd2}) begin
      errors++; $display("FAIL ovf_head: got v%b r%0d x%0d w%0d, required v1 r0 x0 w2", bus.out_valid, bus.out_row, bus.out_x, bus.out_width);
    end
`ifdef LANE_RUN_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 16'd1) begin errors++; $display("FAIL ovf_drop_cnt: got %0d, required 1", drop_cnt); end
`endif
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    idle(6);
    checks++;
    if (rec_q.size() != 4) begin errors++; $display("FAIL ovf_count: got %0d, required 4", rec_q.size()); end
    for (int i = 0; i < 4 && i < rec_q.size(); i++) begin
      checks++;
      if (rec_q[i] !== {2'd0, 4'(3 * i), 5'd2}) begin
        errors++; $display("FAIL ovf_rec%0d: got %h, required %h", i, rec_q[i], {2'd0, 4'(3 * i), 5'd2});
      end
    end
  endtask

  task automatic test_full_push_pop();
    logic [15:0] bits;
    bits = 16'b1101101101101100;
    bus.out_ready = 1'b0;
    rec_q.delete();
    for (int c = 0; c < 16; c++) begin
      @(posedge clk);
      #1;
      bus.pix_valid = 1'b1;
      bus.pix_bit   = bits[15-c];
      bus.out_ready = (c == 14);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || {bus.out_row, bus.out_x, bus.out_width} !== {2'd1, 4'd3, 5'd2}) begin
      errors++; $display("FAIL pp_head: got v%b r%0d x%0d w%0d, required v1 r1 x3 w2", bus.out_valid, bus.out_row, bus.out_x, bus.out_width);
    end
`ifdef LANE_RUN_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 16'd1) begin errors++; $display("FAIL pp_drop_cnt: got %0d, required 1", drop_cnt); end
`endif
    @(posedge clk);
    #1;
    bus.pix_valid = 1'b0;
    bus.out_ready = 1'b1;
    idle(6);
    checks++;
    if (rec_q.size() != 5) begin errors++; $display("FAIL pp_count: got %0d, required 5", rec_q.size()); end
    for (int i = 0; i < 5 && i < rec_q.size(); i++) begin
      checks++;
      if (rec_q[i] !== {2'd1, 4'(3 * i), 5'd2}) begin
        errors++; $display("FAIL pp_rec%0d: got %h, required %h", i, rec_q[i], {2'd1, 4'(3 * i), 5'd2});
      end
    end
  endtask

  task automatic test_frame_end();
    int fe0;
    fe0 = fe_cnt;
    drive_row(16'd0);
    drive_row(16'd0);
    step(1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (frame_end !== 1'b1) begin errors++; $display("FAIL fe_pulse: got %b, required 1", frame_end); end
    step(1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (frame_end !== 1'b0) begin errors++; $display("FAIL fe_clear: got %b, required 0", frame_end); end
    step(1'b0, 1'b0);
    checks++;
    if (fe_cnt != fe0 + 1) begin errors++; $display("FAIL fe_count: got %0d, required %0d", fe_cnt, fe0 + 1); end
    rec_q.delete();
    drive_row(16'b1110000000000000);
    idle(2);
    checks++;
    if (rec_q.size() != 1 || rec_q[0] !== {2'd0, 4'd0, 5'd3}) begin
      errors++; $display("FAIL fe_wrap_pos: got %0d records, required one r0 x0 w3", rec_q.size());
    end
  endtask

  task automatic test_reset_mid_run();
    bus.out_ready = 1'b0;
    rec_q.delete();
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mid_queued: got %b, required 1", bus.out_valid); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || {bus.out_row, bus.out_x, bus.out_width} !== 11'd0 || frame_end !== 1'b0) begin
      errors++; $display("FAIL mid_reset_out: got v%b fields %h fe%b, required all 0", bus.out_valid, {bus.out_row, bus.out_x, bus.out_width}, frame_end);
    end
`ifdef LANE_RUN_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 16'd0) begin errors++; $display("FAIL mid_drop_cnt: got %0d, required 0", drop_cnt); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    idle(3);
    checks++;
    if (rec_q.size() != 0) begin errors++; $display("FAIL mid_no_record: got %0d, required 0", rec_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_run();
    test_width_filter();
    test_end_of_line();
    test_overflow();
    test_full_push_pop();
    test_frame_end();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lane_run_detector.md
# lane_run_detector

Downstream consumer of the binary lane-mask pixel stream, sitting in parallel with the `shift_register` neighbourhood windows. It tracks row/column position, finds horizontal runs of set mask pixels, filters them by width, and queues qualifying runs as {row, x_start, width} records. The records go through a small FIFO with a valid/ready output for the lane-fitting stage.

## Interface
- IMG_W, 640: pixels per row.
- IMG_H, 480: rows per frame.
- MIN_W, 3: minimum run width accepted, inclusive.
- MAX_W, 40: maximum run width accepted, inclusive.
- FIFO_DEPTH, 4: record queue depth, power of two, ≥2.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- pix_valid  in  1  pixel strobe; this is the same enable that drives the mask shift register.
- pix_bit  in  1  binary mask pixel: 1 = lane candidate.
- out_valid  out  1  record available.
- out_ready  in  1  consumer accepts the record.
- out_row  out  $clog2(IMG_H)  row of the run.
- out_x  out  $clog2(IMG_W)  column of the first set pixel.
- out_width  out  $clog2(IMG_W+1)  run length in pixels.
- frame_end  out  1  one-cycle pulse on the last pixel of a frame.
- drop_cnt  out  16  saturating count of qualifying runs lost to a full FIFO; present only with the macro.

## Operation
- Position:
  - The column counter increments on each pix_valid pixel and wraps at IMG_W-1 → 0.
  - The row counter increments on the column wrap and wraps at IMG_H-1 → 0.
  - No pixels are inserted or skipped.
- FSM has two states, IDLE and RUN.
- IDLE:
  - pix_bit=1 → RUN, latching x_start=col and len=1.
  - If col=IMG_W-1, the run terminates immediately with len=1 and the FSM stays in IDLE.
- RUN:
  - pix_bit=1 → len+1.
  - pix_bit=0 → terminate with the current len; the 0 pixel is not counted. Go to IDLE.
  - On col=IMG_W-1, the run terminates at end of line. The pixel is included if it is 1. Go to IDLE. Runs never span rows.
- Termination:
  - If MIN_W ≤ width ≤ MAX_W, a record {row of run, x_start, width} is pushed.
  - Otherwise the run is discarded silently.
- FIFO:
  - Push is accepted if not full, or if full with a pop in the same cycle.
  - A qualifying run with no space is dropped, and drop_cnt increments if enabled.
  - Output is first-word-fall-through: out_* always reflect the head entry, stable while out_valid=1 and out_ready=0.
  - Pop occurs on out_valid & out_ready.
- frame_end is asserted in the cycle after the edge sampling pixel (row IMG_H-1, col IMG_W-1). It is independent of the FIFO.
- pix_valid=0 freezes the counters and FSM; the FIFO may still drain.

## Timing
- Reset values:
  - col=0, row=0, FSM=IDLE, FIFO empty.
  - out_valid=0, out_row=0, out_x=0, out_width=0, frame_end=0, drop_cnt=0.
- Latency: the record is written on the edge that samples the terminating pixel. out_valid rises the cycle after, i.e. 1 cycle.
- Throughput: one pixel per cycle sustained, and one pop per cycle.
- Simultaneous push/pop on an empty FIFO: not possible, since pop requires out_valid.
- Simultaneous push/pop on a full FIFO: both occur and the count is unchanged.
- rst_n assertion mid-run or mid-frame: immediate asynchronous return to reset values. Any partial run and queued records are lost.

## Configuration
- LANE_RUN_DROP_CNT_EN defined:
  - The drop_cnt port and its counter exist.
  - The counter saturates at 16'hFFFF and clears only on reset.
- Undefined: no port and no counter. Overflow runs are still dropped silently.

## Structure
- lane_pkg holds:
  - the lane_run_t packed struct {row, x, width};
  - width-function localparams derived from IMG_W/IMG_H.
- Sub-module lane_run_fifo:
  - parameterized on depth and the lane_run_t payload;
  - synchronous FWFT, with full/empty flags;
  - async reset clears the pointers.

## Test plan
Bench config: IMG_W=16, IMG_H=4, MIN_W=2, MAX_W=6, FIFO_DEPTH=4.
- Row 0 pixels 0001111000000000, out_ready=1 → one record {row 0, x 3, width 4}, out_valid high 1 cycle after the col-7 pixel.
- Row 1 with runs of width 1 at x=2 and width 7 at x=5 → no records.
- Row 2 ends with 1s at cols 13–15 → record {row 2, x 13, width 3}. A 1 at col 0 of row 3 starts a new run and does not merge.
- out_ready=0 and 5 qualifying runs → first 4 records retained in order, 5th dropped, drop_cnt=1 (macro on); release ready → 4 records in order.
- Full FIFO with push and pop in the same cycle → both accepted, out_valid stays 1, no drop.
- 64 pixels streamed → frame_end pulses once after pixel (3,15), counters back to (0,0); rst_n pulsed mid-run → outputs at reset values, no record for the interrupted run.
